approx_adder_arbiter: RTL

- Round-robin arbiter and sequencer that shares one combinational 16-bit approximate ripple-carry adder among N_REQ requesters.
- The shared adder has 11 approximate LSB cells (each cell: sum = a bit, carry-out = b bit) and exact full adders above them. It is instantiated outside this block and connected through the adder_* ports.
- The block registers operands, captures the adder result, and returns it with the requester ID.
- It also keeps a saturating count of results that differ from the exact sum, for runtime error monitoring.

---
 rtl/approx_adder_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/approx_adder_arbiter.sv
// Round-robin sequencer that time-shares one external approximate adder among
// N_REQ requesters and counts results that differ from the exact sum.
module approx_adder_arbiter #(
    parameter int          N_REQ   = 4,
    parameter int          WIDTH   = 16,
    parameter int          ID_W    = 2,
    parameter logic [15:0] ERR_SAT = 16'hFFFF  // value at which err_cnt stops counting
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]       adder_a,
    output logic [WIDTH-1:0]       adder_b,
    input  logic [WIDTH:0]         adder_sum,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH:0]         rsp_sum,
    output logic [ID_W-1:0]        rsp_id,
    input  logic                   err_clr,
    output logic [15:0]            err_cnt
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [WIDTH-1:0]  op_a_reg, op_b_reg;
    logic [WIDTH:0]    rsp_sum_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [15:0]       err_cnt_reg;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   cand_id;
    logic [WIDTH:0]    exact_sum;
    logic [WIDTH-1:0]  a_arr [N_REQ];
    logic [WIDTH-1:0]  b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from farthest to nearest so the first valid index after rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand_id = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
            if (req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == IDLE && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_found) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign exact_sum = {1'b0, op_a_reg} + {1'b0, op_b_reg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= ID_W'(N_REQ - 1);
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            rsp_sum_reg <= '0;
            rsp_id_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && grant_found) begin
                op_a_reg   <= a_arr[grant_id];
                op_b_reg   <= b_arr[grant_id];
                rsp_id_reg <= grant_id;
                rr_ptr_reg <= grant_id;
            end
            if (state_reg == EXEC) begin
                rsp_sum_reg <= adder_sum;
            end
            // A clear always beats a same-cycle increment.
            if (err_clr) begin
                err_cnt_reg <= '0;
            end else if (state_reg == EXEC && exact_sum != adder_sum
                         && err_cnt_reg != ERR_SAT) begin
                err_cnt_reg <= err_cnt_reg + 16'd1;
            end
        end
    end

    assign adder_a   = op_a_reg;
    assign adder_b   = op_b_reg;
    assign rsp_valid = (state_reg == RESP);
    assign rsp_sum   = rsp_sum_reg;
    assign rsp_id    = rsp_id_reg;
    assign err_cnt   = err_cnt_reg;
endmodule
